// File: rtl/studio2_kp_pkg.sv
// Purpose : shared constants, scan-code tables and decode helpers for the Studio II keypad responder.
// Latency : n/a (package, no logic of its own).
// Backpr. : n/a.
// Contents: KP_LATCH_PORT, KP1_CODE/KP2_CODE scan-code tables, keyvec_t, kp1_hits/kp2_hits decoders.
package studio2_kp_pkg;

    // CPU N-line value that addresses the key-select latch (OUT 2).
    localparam logic [2:0] KP_LATCH_PORT = 3'd2;

    localparam int KP_KEYS = 10;

    typedef logic [9:0] keyvec_t;

    // PS/2 set-2 scan codes, index = key number 0..9.
    // Keypad 1 uses the main-row digits, keypad 2 the numeric keypad.
    localparam logic [7:0] KP1_CODE [KP_KEYS] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };
    localparam logic [7:0] KP2_CODE [KP_KEYS] = '{
        8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D
    };

    // One-hot match of a scan code against a keypad table (all-zero if no match).
    function automatic keyvec_t kp1_hits(input logic [7:0] code);
        keyvec_t v;
        v = '0;
        for (int k = 0; k < KP_KEYS; k++) begin
            v[k] = (code == KP1_CODE[k]);
        end
        return v;
    endfunction

    function automatic keyvec_t kp2_hits(input logic [7:0] code);
        keyvec_t v;
        v = '0;
        for (int k = 0; k < KP_KEYS; k++) begin
            v[k] = (code == KP2_CODE[k]);
        end
        return v;
    endfunction

endpackage

// File: rtl/studio2_key_cell.sv
// Purpose : state of one keypad key: raw pressed flag plus a hold counter that stretches short presses.
// Latency : press/release pulse at cycle N -> o_eff updated at N+1.
// Backpr. : none; every press/release pulse is consumed in the cycle it is presented.
// Ports   : clk, resetq (async active-low), i_press, i_release (one-cycle pulses), o_eff (effective state).
module studio2_key_cell #(
    parameter int HOLD_CYCLES = 500000,
    parameter int HOLD_W      = 20
) (
    input  logic clk,
    input  logic resetq,
    input  logic i_press,
    input  logic i_release,
    output logic o_eff
);

    logic              r_raw;
    logic [HOLD_W-1:0] r_cnt;

    // A release leaves the counter alone, so a press immediately followed by a
    // release keeps the key visible for the full hold window.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_raw <= 1'b0;
            r_cnt <= '0;
        end else if (i_press) begin
            r_raw <= 1'b1;
            r_cnt <= HOLD_W'(HOLD_CYCLES);
        end else if (i_release) begin
            r_raw <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_eff = r_raw | (r_cnt != '0);

endmodule

// File: rtl/studio2_keypad.sv
// Purpose : CDP1802 keypad responder; decodes ps2_key events into key states, answers on EF3/EF4 for the
//           key chosen with OUT 2. Keypad 2 is built only when STUDIO2_KEYPAD2_EN is defined.
// Latency : OUT 2 at N -> key_latch at N+1 -> ef at N+2; ps2 event at N -> key state N+1 -> ef at N+2.
// Backpr. : none; ps2 events and OUT strobes are accepted every cycle.
// Ports   : clk, resetq (async active-low), ps2_key[10:0], io_n[2:0], io_out, io_dout[7:0],
//           ef3, ef4, key_latch[3:0], any_key.
module studio2_keypad
    import studio2_kp_pkg::*;
#(
    parameter int HOLD_CYCLES = 500000,
    parameter int HOLD_W      = 20
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [10:0] ps2_key,
    input  logic [2:0]  io_n,
    input  logic        io_out,
    input  logic [7:0]  io_dout,
    output logic        ef3,
    output logic        ef4,
    output logic [3:0]  key_latch,
    output logic        any_key
);

    logic    r_tog_q;
    logic    r_armed;
    logic    r_ef3;
    logic [3:0] r_latch;

    logic    w_event;
    logic    w_std;
    logic    w_prs;
    logic    w_rel;
    keyvec_t w_hit1;
    keyvec_t w_hit2;
    keyvec_t w_eff1;
    keyvec_t w_eff2;
    logic    w_unused;

    // The first cycle after reset only samples the toggle bit, so a toggle
    // level that happens to be high at reset release is not seen as an event.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_tog_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_tog_q <= ps2_key[10];
            r_armed <= 1'b1;
        end
    end

    assign w_event = r_armed & (r_tog_q ^ ps2_key[10]);
    // Extended (E0-prefixed) codes never map to a keypad key.
    assign w_std   = w_event & ~ps2_key[8];
    assign w_prs   = w_std & ps2_key[9];
    assign w_rel   = w_std & ~ps2_key[9];
    assign w_hit1  = kp1_hits(ps2_key[7:0]);
    assign w_hit2  = kp2_hits(ps2_key[7:0]);

    for (genvar g = 0; g < KP_KEYS; g++) begin : g_kp1
        studio2_key_cell #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .HOLD_W      (HOLD_W)
        ) u_cell (
            .clk       (clk),
            .resetq    (resetq),
            .i_press   (w_prs & w_hit1[g]),
            .i_release (w_rel & w_hit1[g]),
            .o_eff     (w_eff1[g])
        );
    end

`ifdef STUDIO2_KEYPAD2_EN
    logic r_ef4;

    for (genvar g = 0; g < KP_KEYS; g++) begin : g_kp2
        studio2_key_cell #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .HOLD_W      (HOLD_W)
        ) u_cell (
            .clk       (clk),
            .resetq    (resetq),
            .i_press   (w_prs & w_hit2[g]),
            .i_release (w_rel & w_hit2[g]),
            .o_eff     (w_eff2[g])
        );
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_ef4 <= 1'b0;
        end else begin
            r_ef4 <= (r_latch <= 4'd9) ? w_eff2[r_latch] : 1'b0;
        end
    end

    assign ef4      = r_ef4;
    assign w_unused = ^io_dout[7:4];
`else
    // Keypad 2 absent: its codes decode to nothing and ef4 never asserts.
    assign w_eff2   = '0;
    assign ef4      = 1'b0;
    assign w_unused = ^{io_dout[7:4], w_hit2};
`endif

    // Latch and EF share one register stage; EF uses the latch value already
    // updated, which gives the two-cycle OUT-to-EF path.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_latch <= 4'd0;
            r_ef3   <= 1'b0;
        end else begin
            if (io_out && (io_n == KP_LATCH_PORT)) begin
                r_latch <= io_dout[3:0];
            end
            r_ef3 <= (r_latch <= 4'd9) ? w_eff1[r_latch] : 1'b0;
        end
    end

    assign ef3       = r_ef3;
    assign key_latch = r_latch;
    assign any_key   = (|w_eff1) | (|w_eff2);

endmodule
